// File: rtl/bsg_gateway_test_pkg.sv
// Shared definitions for the gateway test sequencer.
//
// Contents:
//   bsg_gw_seq_state_e                  - sequencer FSM states
//   bsg_gw_default_settle_cycles_lp     - default post-calibration settle time
//   bsg_gw_default_timeout_cycles_lp    - default per-node RUN cycle limit
package bsg_gateway_test_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_RUN    = 3'd2,
    S_REPORT = 3'd3,
    S_DONE   = 3'd4,
    S_FAIL   = 3'd5
  } bsg_gw_seq_state_e;

  localparam int unsigned bsg_gw_default_settle_cycles_lp  = 16;
  localparam int unsigned bsg_gw_default_timeout_cycles_lp = 32'd1 << 20;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear.
//
// Ports:
//   clk_i    - clock
//   reset_i  - synchronous active-high reset, forces count to zero
//   clear_i  - restart the count; if up_i is also set the count restarts at 1
//   up_i     - increment enable
//   count_o  - current count (wraps; callers that need saturation gate up_i)
module bsg_counter_clear_up
  #(parameter int width_p = 32)
  (input  logic               clk_i,
   input  logic               reset_i,
   input  logic               clear_i,
   input  logic               up_i,
   output logic [width_p-1:0] count_o);

  // Clear takes priority over the running value but still honours up_i,
  // so a clear-and-count in the same cycle lands on 1 rather than 0.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_o <= '0;
    end else if (clear_i) begin
      count_o <= width_p'(up_i);
    end else begin
      count_o <= count_o + width_p'(up_i);
    end
  end

endmodule

// File: rtl/bsg_gateway_test_sequencer.sv
// Gateway test sequencer: once the core-calibration reset drops, waits a
// settle period, then enables each master test node in turn, measures how
// many core cycles it takes to raise its done flag, and enforces a per-node
// timeout. Ends in a sticky finish or a sticky fail.
//
// Ports:
//   clk_i          - gateway core clock
//   reset_n_i      - synchronous active-low reset
//   calib_reset_i  - guts core reset (active high); restarts sequencing
//   node_done_i    - per-node done levels
//   node_en_o      - one-hot enable of the node under test
//   cur_node_o     - index of the current node
//   cycles_o       - measured cycle count of the node last reported
//   cycles_v_o     - one-cycle strobe qualifying cycles_o / cur_node_o
//   finish_o       - sticky, all nodes completed
//   fail_o         - sticky, a node timed out
//   fail_node_o    - index of the node that timed out
module bsg_gateway_test_sequencer
  import bsg_gateway_test_pkg::*;
  #(parameter int          nodes_p          = 1,
    parameter int          ctr_width_p      = 32,
    parameter int unsigned settle_cycles_p  = bsg_gw_default_settle_cycles_lp,
    parameter int unsigned timeout_cycles_p = bsg_gw_default_timeout_cycles_lp,
    localparam int         node_id_width_lp = (nodes_p > 1) ? $clog2(nodes_p) : 1)
  (input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        calib_reset_i,
   input  logic [nodes_p-1:0]          node_done_i,
   output logic [nodes_p-1:0]          node_en_o,
   output logic [node_id_width_lp-1:0] cur_node_o,
   output logic [ctr_width_p-1:0]      cycles_o,
   output logic                        cycles_v_o,
   output logic                        finish_o,
   output logic                        fail_o,
   output logic [node_id_width_lp-1:0] fail_node_o);

  localparam int settle_width_lp = (settle_cycles_p > 1) ? $clog2(settle_cycles_p) : 1;
  localparam logic [settle_width_lp-1:0]  settle_last_lp = settle_width_lp'(settle_cycles_p - 1);
  localparam logic [node_id_width_lp-1:0] last_node_lp   = node_id_width_lp'(nodes_p - 1);
  localparam logic [ctr_width_p-1:0]      timeout_lp     = ctr_width_p'(timeout_cycles_p);

  bsg_gw_seq_state_e             state_r, state_n;
  logic [node_id_width_lp-1:0]   cur_node_r, cur_node_n;
  logic [settle_width_lp-1:0]    settle_cnt_r, settle_cnt_n;
  logic [ctr_width_p-1:0]        run_cnt;
  logic [ctr_width_p-1:0]        run_cnt_plus1;
  logic                          run_sat;
  logic [nodes_p-1:0]            cur_onehot;
  logic [nodes_p-1:0]            next_onehot;
  logic                          cur_done;
  logic                          latch_cycles;
  logic                          latch_fail;

  // The run counter only advances in RUN and is held at zero everywhere
  // else, so every entry into RUN starts from a fresh count. Gating up_i at
  // all-ones gives saturation without touching the shared counter.
  assign run_sat = &run_cnt;

  bsg_counter_clear_up #(.width_p(ctr_width_p)) run_counter
    (.clk_i   (clk_i),
     .reset_i (~reset_n_i),
     .clear_i (state_r != S_RUN),
     .up_i    ((state_r == S_RUN) && !run_sat),
     .count_o (run_cnt));

  // The first RUN cycle counts as cycle 1, so the reported length and the
  // timeout compare both use the counter value plus one, saturated.
  assign run_cnt_plus1 = run_sat ? run_cnt : run_cnt + ctr_width_p'(1);

  // Decode the current node into a one-hot for done selection, and the next
  // node into a one-hot so the registered enable lines up with the state.
  always_comb begin
    cur_onehot  = '0;
    next_onehot = '0;
    for (int i = 0; i < nodes_p; i++) begin
      cur_onehot[i]  = (cur_node_r == node_id_width_lp'(i));
      next_onehot[i] = (cur_node_n == node_id_width_lp'(i));
    end
  end

  assign cur_done = |(node_done_i & cur_onehot);

  // Next-state logic. Calibration reset aborts any in-progress sequencing
  // but is deliberately ignored once a final verdict (DONE/FAIL) is reached.
  // In RUN, done is checked ahead of the timeout so a tie reports success.
  always_comb begin
    state_n      = state_r;
    cur_node_n   = cur_node_r;
    settle_cnt_n = settle_cnt_r;
    latch_cycles = 1'b0;
    latch_fail   = 1'b0;

    unique case (state_r)
      S_IDLE: begin
        settle_cnt_n = '0;
        cur_node_n   = '0;
        if (!calib_reset_i) begin
          state_n = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (calib_reset_i) begin
          state_n      = S_IDLE;
          settle_cnt_n = '0;
          cur_node_n   = '0;
        end else if (settle_cnt_r == settle_last_lp) begin
          state_n      = S_RUN;
          settle_cnt_n = '0;
          cur_node_n   = '0;
        end else begin
          settle_cnt_n = settle_cnt_r + settle_width_lp'(1);
        end
      end

      S_RUN: begin
        if (calib_reset_i) begin
          state_n    = S_IDLE;
          cur_node_n = '0;
        end else if (cur_done) begin
          state_n      = S_REPORT;
          latch_cycles = 1'b1;
        end else if (run_cnt_plus1 == timeout_lp) begin
          state_n    = S_FAIL;
          latch_fail = 1'b1;
        end
      end

      S_REPORT: begin
        if (calib_reset_i) begin
          state_n    = S_IDLE;
          cur_node_n = '0;
        end else if (cur_node_r == last_node_lp) begin
          state_n = S_DONE;
        end else begin
          state_n    = S_RUN;
          cur_node_n = cur_node_r + node_id_width_lp'(1);
        end
      end

      S_DONE: state_n = S_DONE;

      S_FAIL: state_n = S_FAIL;

      default: begin
        state_n    = S_IDLE;
        cur_node_n = '0;
      end
    endcase
  end

  // State and output registers. Outputs are computed from the next-state
  // values so they are registered yet line up cycle-for-cycle with the
  // state they describe. cycles_o and fail_node_o only change when latched.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r      <= S_IDLE;
      cur_node_r   <= '0;
      settle_cnt_r <= '0;
      node_en_o    <= '0;
      cycles_o     <= '0;
      cycles_v_o   <= 1'b0;
      finish_o     <= 1'b0;
      fail_o       <= 1'b0;
      fail_node_o  <= '0;
    end else begin
      state_r      <= state_n;
      cur_node_r   <= cur_node_n;
      settle_cnt_r <= settle_cnt_n;
      node_en_o    <= (state_n == S_RUN) ? next_onehot : '0;
      cycles_v_o   <= (state_n == S_REPORT);
      finish_o     <= (state_n == S_DONE);
      fail_o       <= (state_n == S_FAIL);
      if (latch_cycles) begin
        cycles_o <= run_cnt_plus1;
      end
      if (latch_fail) begin
        fail_node_o <= cur_node_r;
      end
    end
  end

  assign cur_node_o = cur_node_r;

endmodule
